branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Parametrised branch target buffer (BTB) with 2-bit saturating direction counters.
- Sits beside the fetch stage and predicts the next PC for the current fetch PC.
- The execute-stage branch resolver writes back resolved outcomes to train the table.
- Extends the current resolve-only branch logic with prediction state, training, flush and misprediction statistics.

Parameters:
- XLEN, 32, PC and target width in bits.
- ENTRIES, 16, number of BTB entries; power of two, at least 2; IDX_W = log2(ENTRIES).
- STAT_W, 16, width of each statistics counter.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- lookup_pc  in  XLEN  fetch PC to predict for.
- predict_taken  out  1  prediction is a redirect.
- predict_target  out  XLEN  predicted next PC.
- predict_hit  out  1  lookup_pc matched a valid entry.
- update_valid  in  1  a resolved branch or jump is presented this cycle.
- update_pc  in  XLEN  PC of the resolved instruction.
- update_taken  in  1  resolved direction.
- update_target  in  XLEN  resolved target (rs1+imm for JALR, pc+imm otherwise).
- update_is_jump  in  1  unconditional (JAL/JALR) as opposed to conditional.
- update_mispredict  in  1  resolver detected a wrong prediction; valid only with update_valid.
- flush_all  in  1  synchronous invalidate of every entry.
- lookup_count  out  STAT_W  number of update_valid events seen.
- mispredict_count  out  STAT_W  number of update_valid && update_mispredict events seen.

Behaviour:
- Index = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2]; pc[1:0] is ignored.
- Entry fields: valid, tag, target[XLEN], ctr[1:0], is_jump.
- Lookup is combinational, zero latency, and reads registered state only.
- predict_hit = valid && tag match.
- predict_taken = hit && (is_jump || ctr[1]).
- predict_target = entry target when predict_taken, else lookup_pc + 4, wrapping modulo 2^XLEN.
- Reset (async assert, reset_n=0):
  - all valid=0, ctr=2'b01, target=0, tag=0, is_jump=0.
  - lookup_count=0, mispredict_count=0.
  - Outputs are therefore predict_hit=0, predict_taken=0, predict_target=lookup_pc+4.
  - Reset mid-update discards that update.
- Update, applied at the rising edge when update_valid=1 and flush_all=0:
  - Hit, taken: ctr saturating increment (max 2'b11); target := update_target; is_jump := update_is_jump.
  - Hit, not taken: ctr saturating decrement (min 2'b00); target unchanged.
  - Miss, taken: allocate or replace the direct-mapped slot. Set valid=1, tag, target; ctr=2'b11 if is_jump, else 2'b10.
  - Miss, not taken: no table change.
  - A jump is never trained not-taken. If update_is_jump=1 and update_taken=0, treat as taken.
- Simultaneous lookup and update to the same index: lookup returns the pre-update value. There is no write-through bypass; the new value is visible the next cycle.
- flush_all=1: all valid cleared at the edge, ctr/target untouched. It has priority over a same-cycle update, which is dropped. Statistics still count that update.
- Statistics:
  - lookup_count increments on each update_valid.
  - mispredict_count increments on update_valid && update_mispredict.
  - Both saturate at all-ones (no wrap).
  - Neither is cleared by flush_all.
- update_mispredict without update_valid is ignored.

Decomposition:
- Shared defines header gains: CTR_WEAK_NT 2'b01, CTR_WEAK_T 2'b10, CTR_STRONG_T 2'b11. It sits alongside the existing BRANCH_* type codes.
- One sub-module is natural: sat_counter2, a pure 2-bit saturating inc/dec function block.
- The table arrays and statistics counters remain inline.

Test Plan:
- Reset, then lookup_pc=0x100 -> predict_hit=0, predict_taken=0, predict_target=0x104; both counts 0.
- Update pc=0x100, taken, target=0x200, not jump; next cycle lookup 0x100 -> hit=1, taken=1 (ctr=10), target=0x200.
  - One further not-taken update -> ctr=01, predict_taken=0, predict_target=0x104.
- Saturation: with the 0x100 entry at ctr=10, apply 3 taken updates (ctr stays 11), then 1 not-taken -> still predicts taken (ctr=10). Then 2 more not-taken -> ctr=00; a 3rd not-taken holds ctr=00.
- Aliasing: ENTRIES=16, train 0x100 taken, then train 0x140 taken to target 0x300 (same index, different tag).
  - Lookup 0x100 -> hit=0.
  - Lookup 0x140 -> target 0x300.
- Same-cycle update and lookup at 0x180: lookup shows the old miss; the following cycle shows the hit.
  - With flush_all asserted in the same cycle as an update, the entry stays invalid.
  - lookup_count still increments.
- STAT_W=4: apply 20 updates, all mispredicted -> lookup_count=15, mispredict_count=15.
  - Then pulse reset_n low mid-stream -> both counts 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared branch type codes and direction-counter encodings.
package branch_predictor_pkg;

  // Branch type codes used by the resolver.
  typedef enum logic [1:0] {
    BRANCH_NONE = 2'b00,
    BRANCH_COND = 2'b01,
    BRANCH_JAL  = 2'b10,
    BRANCH_JALR = 2'b11
  } branch_type_e;

  // 2-bit direction counter encodings; bit 1 set means predict taken.
  localparam logic [1:0] CTR_STRONG_NT = 2'b00;
  localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
  localparam logic [1:0] CTR_WEAK_T    = 2'b10;
  localparam logic [1:0] CTR_STRONG_T  = 2'b11;

endpackage : branch_predictor_pkg

// File: rtl/branch_predictor_sat_counter2.sv
// Pure 2-bit saturating increment/decrement.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       inc,
  output logic [1:0] ctr_next_c
);

  // Step toward strongly-taken on inc, toward strongly-not-taken otherwise.
  always_comb begin
    ctr_next_c = ctr;
    if (inc) begin
      if (ctr != CTR_STRONG_T) ctr_next_c = ctr + 2'd1;
    end else begin
      if (ctr != CTR_STRONG_NT) ctr_next_c = ctr - 2'd1;
    end
  end

endmodule : sat_counter2

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters and resolve statistics.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned STAT_W  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [XLEN-1:0]   lookup_pc,
  output logic              predict_taken,
  output logic [XLEN-1:0]   predict_target,
  output logic              predict_hit,
  input  logic              update_valid,
  input  logic [XLEN-1:0]   update_pc,
  input  logic              update_taken,
  input  logic [XLEN-1:0]   update_target,
  input  logic              update_is_jump,
  input  logic              update_mispredict,
  input  logic              flush_all,
  output logic [STAT_W-1:0] lookup_count,
  output logic [STAT_W-1:0] mispredict_count
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [XLEN-1:0]    target_d [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  logic [1:0]         ctr_d    [ENTRIES];
  logic [ENTRIES-1:0] is_jump_q, is_jump_d;
  logic [STAT_W-1:0]  lookup_count_q, lookup_count_d;
  logic [STAT_W-1:0]  mispredict_count_q, mispredict_count_d;

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             up_hit, up_taken;
  logic [1:0]       up_ctr_next;
  logic             unused_pc_lsbs;

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[XLEN-1:IDX_W+2];
  assign up_idx = update_pc[IDX_W+1:2];
  assign up_tag = update_pc[XLEN-1:IDX_W+2];
  assign unused_pc_lsbs = ^{lookup_pc[1:0], update_pc[1:0]};

  // Jumps always train as taken.
  assign up_taken = update_taken | update_is_jump;
  assign up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  sat_counter2 u_sat (
    .ctr        (ctr_q[up_idx]),
    .inc        (up_taken),
    .ctr_next_c (up_ctr_next)
  );

  // Zero-latency lookup from registered state only (no write bypass).
  always_comb begin
    predict_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    predict_taken  = predict_hit && (is_jump_q[lk_idx] || ctr_q[lk_idx][1]);
    predict_target = predict_taken ? target_q[lk_idx] : lookup_pc + XLEN'(4);
  end

  // Table training; flush wins over a same-cycle update.
  always_comb begin
    valid_d   = valid_q;
    tag_d     = tag_q;
    target_d  = target_q;
    ctr_d     = ctr_q;
    is_jump_d = is_jump_q;
    if (flush_all) begin
      valid_d = '0;
    end else if (update_valid) begin
      if (up_hit) begin
        ctr_d[up_idx] = up_ctr_next;
        if (up_taken) begin
          target_d[up_idx]  = update_target;
          is_jump_d[up_idx] = update_is_jump;
        end
      end else if (up_taken) begin
        valid_d[up_idx]   = 1'b1;
        tag_d[up_idx]     = up_tag;
        target_d[up_idx]  = update_target;
        ctr_d[up_idx]     = update_is_jump ? CTR_STRONG_T : CTR_WEAK_T;
        is_jump_d[up_idx] = update_is_jump;
      end
    end
  end

  // Saturating statistics; flush does not clear them.
  always_comb begin
    lookup_count_d     = lookup_count_q;
    mispredict_count_d = mispredict_count_q;
    if (update_valid && (lookup_count_q != '1))
      lookup_count_d = lookup_count_q + STAT_W'(1);
    if (update_valid && update_mispredict && (mispredict_count_q != '1))
      mispredict_count_d = mispredict_count_q + STAT_W'(1);
  end

  assign lookup_count     = lookup_count_q;
  assign mispredict_count = mispredict_count_q;

  // State registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q            <= '0;
      is_jump_q          <= '0;
      lookup_count_q     <= '0;
      mispredict_count_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WEAK_NT;
      end
    end else begin
      valid_q            <= valid_d;
      is_jump_q          <= is_jump_d;
      lookup_count_q     <= lookup_count_d;
      mispredict_count_q <= mispredict_count_d;
      tag_q              <= tag_d;
      target_q           <= target_d;
      ctr_q              <= ctr_d;
    end
  end

endmodule : branch_predictor

// File: tb/tb_branch_predictor.sv
// Directed checks of BTB lookup, training, flush and statistics.
module tb_branch_predictor;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned ENTRIES = 16;
  localparam int unsigned STAT_W  = 4;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [XLEN-1:0]   lookup_pc;
  logic              predict_taken;
  logic [XLEN-1:0]   predict_target;
  logic              predict_hit;
  logic              update_valid;
  logic [XLEN-1:0]   update_pc;
  logic              update_taken;
  logic [XLEN-1:0]   update_target;
  logic              update_is_jump;
  logic              update_mispredict;
  logic              flush_all;
  logic [STAT_W-1:0] lookup_count;
  logic [STAT_W-1:0] mispredict_count;

  int n_checks = 0;
  int n_errors = 0;

  branch_predictor #(.XLEN(XLEN), .ENTRIES(ENTRIES), .STAT_W(STAT_W)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .lookup_pc         (lookup_pc),
    .predict_taken     (predict_taken),
    .predict_target    (predict_target),
    .predict_hit       (predict_hit),
    .update_valid      (update_valid),
    .update_pc         (update_pc),
    .update_taken      (update_taken),
    .update_target     (update_target),
    .update_is_jump    (update_is_jump),
    .update_mispredict (update_mispredict),
    .flush_all         (flush_all),
    .lookup_count      (lookup_count),
    .mispredict_count  (mispredict_count)
  );

  always #5 clock = ~clock;

  // Single comparison point: counts and reports.
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  // One resolved update, held across one rising edge.
  task automatic do_update(input logic [XLEN-1:0] pc, input logic taken,
                           input logic [XLEN-1:0] tgt, input logic jump,
                           input logic misp, input logic flush);
    @(negedge clock);
    update_valid      = 1'b1;
    update_pc         = pc;
    update_taken      = taken;
    update_target     = tgt;
    update_is_jump    = jump;
    update_mispredict = misp;
    flush_all         = flush;
    @(posedge clock);
    #1;
    update_valid      = 1'b0;
    update_mispredict = 1'b0;
    flush_all         = 1'b0;
  endtask

  task automatic look(input string tag, input logic [XLEN-1:0] pc, input logic hit,
                      input logic taken, input logic [XLEN-1:0] tgt);
    @(negedge clock);
    lookup_pc = pc;
    #1;
    check({tag, ".hit"}, 64'(predict_hit), 64'(hit));
    check({tag, ".taken"}, 64'(predict_taken), 64'(taken));
    check({tag, ".target"}, 64'(predict_target), 64'(tgt));
  endtask

  initial begin
    reset_n = 1'b0; lookup_pc = '0; update_valid = 1'b0; update_pc = '0;
    update_taken = 1'b0; update_target = '0; update_is_jump = 1'b0;
    update_mispredict = 1'b0; flush_all = 1'b0;
    #12;
    reset_n = 1'b1;

    // Reset state.
    look("rst", 32'h100, 1'b0, 1'b0, 32'h104);
    check("rst.lcnt", 64'(lookup_count), 64'd0);
    check("rst.mcnt", 64'(mispredict_count), 64'd0);

    // Allocate (ctr=10), then weaken to 01.
    do_update(32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
    look("alloc", 32'h100, 1'b1, 1'b1, 32'h200);
    check("alloc.lcnt", 64'(lookup_count), 64'd1);
    do_update(32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    look("weak_nt", 32'h100, 1'b1, 1'b0, 32'h104);

    // Saturation: back to 10, 3 taken -> 11, 1 NT -> 10.
    do_update(32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) do_update(32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
    do_update(32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    look("sat_hi", 32'h100, 1'b1, 1'b1, 32'h200);
    // Two NT -> 00, third holds at 00.
    do_update(32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    do_update(32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    look("ctr00", 32'h100, 1'b1, 1'b0, 32'h104);
    do_update(32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    look("sat_lo", 32'h100, 1'b1, 1'b0, 32'h104);
    // From 00 one taken gives 01 (still NT), another gives 10.
    do_update(32'h100, 1'b1, 32'h280, 1'b0, 1'b0, 1'b0);
    look("lo_inc1", 32'h100, 1'b1, 1'b0, 32'h104);
    do_update(32'h100, 1'b1, 32'h280, 1'b0, 1'b0, 1'b0);
    look("lo_inc2", 32'h100, 1'b1, 1'b1, 32'h280);

    // Aliasing on index 0.
    do_reset();
    do_update(32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
    do_update(32'h140, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
    look("alias_old", 32'h100, 1'b0, 1'b0, 32'h104);
    look("alias_new", 32'h140, 1'b1, 1'b1, 32'h300);

    // Jump with taken=0 trains as taken; stays strong.
    do_update(32'h200, 1'b0, 32'h400, 1'b1, 1'b0, 1'b0);
    look("jmp_alloc", 32'h200, 1'b1, 1'b1, 32'h400);
    do_update(32'h200, 1'b0, 32'h400, 1'b1, 1'b0, 1'b0);
    look("jmp_nt", 32'h200, 1'b1, 1'b1, 32'h400);

    // Same-cycle update and lookup: old miss now, hit after the edge.
    @(negedge clock);
    lookup_pc = 32'h180; update_valid = 1'b1; update_pc = 32'h180;
    update_taken = 1'b1; update_target = 32'h500; update_is_jump = 1'b0;
    #1;
    check("same.hit_before", 64'(predict_hit), 64'd0);
    check("same.tgt_before", 64'(predict_target), 64'h184);
    @(posedge clock);
    #1;
    update_valid = 1'b0;
    check("same.hit_after", 64'(predict_hit), 64'd1);
    check("same.tgt_after", 64'(predict_target), 64'h500);

    // Flush with same-cycle update: update dropped, table invalid, stats count.
    do_update(32'h1C0, 1'b1, 32'h600, 1'b0, 1'b0, 1'b1);
    look("flush_upd", 32'h1C0, 1'b0, 1'b0, 32'h1C4);
    look("flush_old", 32'h180, 1'b0, 1'b0, 32'h184);
    check("flush.lcnt", 64'(lookup_count), 64'd6);

    // Mispredict without valid is ignored.
    @(negedge clock);
    update_mispredict = 1'b1;
    @(posedge clock);
    #1;
    update_mispredict = 1'b0;
    check("misp_novalid.mcnt", 64'(mispredict_count), 64'd0);
    check("misp_novalid.lcnt", 64'(lookup_count), 64'd6);

    // Statistics saturate at all-ones.
    do_reset();
    for (int i = 0; i < 20; i++) do_update(32'h700, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    check("stat.lcnt", 64'(lookup_count), 64'd15);
    check("stat.mcnt", 64'(mispredict_count), 64'd15);

    // Async reset clears counts without a clock edge.
    @(negedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check("areset.lcnt", 64'(lookup_count), 64'd0);
    check("areset.mcnt", 64'(mispredict_count), 64'd0);
    reset_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_branch_predictor
